uart_rx_fifo: RTL

Receive-side byte buffer directly downstream of the UART receive FSM and its shift register. Captures each completed frame: a good frame arrives on the buffer-load pulse, a bad stop bit arrives on the framing-error pulse. Stores each byte with a per-entry framing-error flag and presents it to the CPU-side consumer through a first-word-fall-through valid/ready interface. Tracks overrun when the consumer falls behind.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_fifo_if.sv | 39 +++
 rtl/uart_fifo_mem.sv | 33 +++
 rtl/uart_rx_fifo.sv | 122 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants (data width, FIFO entry).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  // One buffered character plus its stop-bit status.
  typedef struct packed {
    logic                   ferr;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Receive-path push pulses and consumer-side valid/ready bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int OVR_W = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [UART_DATA_W-1:0] rx_byte;
  logic                   rx_load;
  logic                   rx_sfe;
  logic                   rd_ready;
  logic                   clr_overrun;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   rd_ferr;
  logic                   rd_valid;
  logic                   full;
  logic [ADDR_W:0]        count;
  logic                   overrun;
  logic [OVR_W-1:0]       ovr_count;

  modport master (
    output rx_byte, rx_load, rx_sfe, rd_ready, clr_overrun,
    input  rd_data, rd_ferr, rd_valid, full, count, overrun, ovr_count
  );

  modport slave (
    input  rx_byte, rx_load, rx_sfe, rd_ready, clr_overrun,
    output rd_data, rd_ferr, rd_valid, full, count, overrun, ovr_count
  );

endinterface
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_mem
// Description : DEPTH-entry register array, synchronous write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH  = UART_RX_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  rx_entry_t         wdata,
  input  logic [ADDR_W-1:0] raddr,
  output rx_entry_t         rdata
);

  // Contents are qualified by the owner's pointers, so no reset is needed.
  rx_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word-fall-through receive buffer with per-entry framing
//               error flag and sticky, saturating overrun tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int OVR_W = 8
) (
  input  logic          CLOCK,
  input  logic          reset,
  uart_rx_fifo_if.slave bus
);

  localparam int               ADDR_W    = $clog2(DEPTH);
  localparam logic [OVR_W-1:0] C_OVR_MAX = '1;
  localparam logic [ADDR_W:0]  C_ONE     = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             overrun_q, overrun_d;
  logic [OVR_W-1:0] ovr_count_q, ovr_count_d;

  logic      w_push;
  logic      w_pop;
  logic      w_empty;
  logic      w_full;
  logic      w_accept;
  logic      w_drop;
  rx_entry_t w_wr_entry;
  rx_entry_t w_rd_entry;

  always_comb begin
    w_push  = bus.rx_load | bus.rx_sfe;
    w_empty = (wr_ptr_q == rd_ptr_q);
    w_full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
              (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    w_pop   = !w_empty && bus.rd_ready;
    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    w_accept = w_push && (!w_full || w_pop);
    w_drop   = w_push && w_full && !w_pop;

    w_wr_entry.ferr = bus.rx_sfe;
    w_wr_entry.data = bus.rx_byte;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overrun_d   = overrun_q;
    ovr_count_d = ovr_count_q;

    if (w_accept) begin
      wr_ptr_d = wr_ptr_q + C_ONE;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + C_ONE;
    end

    case ({w_accept, w_pop})
      2'b10:   count_d = count_q + C_ONE;
      2'b01:   count_d = count_q - C_ONE;
      default: count_d = count_q;
    endcase

    // An overrun in the clearing cycle survives as the first new event.
    if (w_drop) begin
      overrun_d = 1'b1;
      if (bus.clr_overrun) begin
        ovr_count_d = {{(OVR_W-1){1'b0}}, 1'b1};
      end else if (ovr_count_q != C_OVR_MAX) begin
        ovr_count_d = ovr_count_q + {{(OVR_W-1){1'b0}}, 1'b1};
      end
    end else if (bus.clr_overrun) begin
      overrun_d   = 1'b0;
      ovr_count_d = '0;
    end
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      ovr_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      ovr_count_q <= ovr_count_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (CLOCK),
    .we    (w_accept),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (w_wr_entry),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (w_rd_entry)
  );

  assign bus.rd_data   = w_rd_entry.data;
  assign bus.rd_ferr   = w_rd_entry.ferr;
  assign bus.rd_valid  = !w_empty;
  assign bus.full      = w_full;
  assign bus.count     = count_q;
  assign bus.overrun   = overrun_q;
  assign bus.ovr_count = ovr_count_q;

endmodule
`default_nettype wire
